chan_seq_fsm: RTL and testbench

- Parametrised channel sequencer. Walks NUM_CH input words from highest index down to index 0 and presents one word per beat on a valid/ready output port.
- Supports one-shot and continuous-wrap modes, with start/stop control and a done pulse.
- Sits between a register bank of per-channel values and a single-word consumer, e.g. a serialising bus or debug port.

---
 rtl/chan_seq_fsm.sv | 211 +++++++++++++++++++++
 tb/tb_chan_seq_fsm.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chan_seq_fsm.sv
// chan_seq_fsm: walks NUM_CH channel words from the highest index down to 0
// and presents one word per beat on a valid/ready port. It runs one-shot or
// continuous-wrap, with start/stop control and a one-cycle done pulse.
// Optional build macro CHSEQ_MASK_EN adds a ch_mask port. Only channels whose
// mask bit is set are visited.
module chan_seq_fsm #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4,
    parameter int IDX_W  = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      mode_wrap,
    input  logic [NUM_CH*WIDTH-1:0]   data,
`ifdef CHSEQ_MASK_EN
    input  logic [NUM_CH-1:0]         ch_mask,
`endif
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [IDX_W-1:0]          out_ch,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LP_TOP  = IDX_W'(NUM_CH - 1);
    localparam logic [IDX_W-1:0] LP_ZERO = {IDX_W{1'b0}};

    state_t           r_state;
    state_t           w_next_state;
    logic [IDX_W-1:0] r_ch_idx;
    logic [IDX_W-1:0] w_next_idx;
    logic             r_mode;
    logic             w_next_mode;

    // First channel on start, first channel after a wrap, the channel that
    // ends a pass, the channel after the current one, and "any channel enabled".
    logic [IDX_W-1:0] w_first_start;
    logic [IDX_W-1:0] w_wrap_top;
    logic [IDX_W-1:0] w_lowest;
    logic [IDX_W-1:0] w_next_lower;
    logic             w_any_start;
    logic             w_is_last;
    logic             w_xfer;

`ifdef CHSEQ_MASK_EN
    logic [NUM_CH-1:0] r_mask;
    logic [NUM_CH-1:0] w_next_mask;

    function automatic logic [IDX_W-1:0] f_highest(input logic [NUM_CH-1:0] m);
        logic [IDX_W-1:0] res;
        res = LP_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] f_lowest(input logic [NUM_CH-1:0] m);
        logic [IDX_W-1:0] res;
        res = LP_ZERO;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] f_next_lower(input logic [NUM_CH-1:0] m,
                                                      input logic [IDX_W-1:0]  cur);
        logic [IDX_W-1:0] res;
        res = LP_ZERO;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i] && (i < int'(cur))) res = IDX_W'(i);
        end
        return res;
    endfunction

    assign w_first_start = f_highest(ch_mask);
    assign w_any_start   = |ch_mask;
    assign w_wrap_top    = f_highest(r_mask);
    assign w_lowest      = f_lowest(r_mask);
    assign w_next_lower  = f_next_lower(r_mask, r_ch_idx);
`else
    assign w_first_start = LP_TOP;
    assign w_any_start   = 1'b1;
    assign w_wrap_top    = LP_TOP;
    assign w_lowest      = LP_ZERO;
    assign w_next_lower  = r_ch_idx - IDX_W'(1);
`endif

    assign w_is_last = (r_ch_idx == w_lowest);
    assign w_xfer    = (r_state == S_RUN) && out_ready;

    // State, channel index and mode registers; asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_ch_idx <= LP_ZERO;
            r_mode   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_ch_idx <= w_next_idx;
            r_mode   <= w_next_mode;
        end
    end

`ifdef CHSEQ_MASK_EN
    // Channel mask captured on the accepted start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= {NUM_CH{1'b0}};
        end else begin
            r_mask <= w_next_mask;
        end
    end

    // Load the mask only when a start is accepted in IDLE.
    always_comb begin
        w_next_mask = r_mask;
        if ((r_state == S_IDLE) && start && !stop) begin
            w_next_mask = ch_mask;
        end else begin
            w_next_mask = r_mask;
        end
    end
`endif

    // Next-state and index sequencing; stop overrides start and every transfer.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_ch_idx;
        w_next_mode  = r_mode;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_next_mode = mode_wrap;
                    if (w_any_start) begin
                        w_next_state = S_RUN;
                        w_next_idx   = w_first_start;
                    end else begin
                        w_next_state = S_DONE;
                        w_next_idx   = LP_ZERO;
                    end
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_RUN: begin
                if (stop) begin
                    w_next_state = S_IDLE;
                    w_next_idx   = LP_ZERO;
                end else if (w_xfer) begin
                    if (!w_is_last) begin
                        w_next_idx = w_next_lower;
                    end else if (r_mode) begin
                        w_next_idx = w_wrap_top;
                    end else begin
                        w_next_state = S_DONE;
                        w_next_idx   = LP_ZERO;
                    end
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
                w_next_idx   = LP_ZERO;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = LP_ZERO;
            end
        endcase
    end

    // Output decode from the state register. The data word comes straight from the live input.
    always_comb begin
        out_valid = 1'b0;
        out_data  = {WIDTH{1'b0}};
        out_ch    = LP_ZERO;
        out_last  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (r_state)
            S_RUN: begin
                out_valid = 1'b1;
                out_data  = data[int'(r_ch_idx)*WIDTH +: WIDTH];
                out_ch    = r_ch_idx;
                out_last  = w_is_last;
                busy      = 1'b1;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_chan_seq_fsm.sv
// Testbench for chan_seq_fsm. The reference model keeps a queue of the
// channels still to be sent in the current pass.
module tb_chan_seq_fsm;

    localparam int WIDTH  = 32;
    localparam int NUM_CH = 4;
    localparam int IDX_W  = $clog2(NUM_CH);

    logic                     clk;
    logic                     reset;
    logic                     start;
    logic                     stop;
    logic                     mode_wrap;
    logic [NUM_CH*WIDTH-1:0]  data;
    logic                     out_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic [IDX_W-1:0]         out_ch;
    logic                     out_last;
    logic                     busy;
    logic                     done;
`ifdef CHSEQ_MASK_EN
    logic [NUM_CH-1:0]        ch_mask;
`endif

    chan_seq_fsm #(.WIDTH(WIDTH), .NUM_CH(NUM_CH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .mode_wrap (mode_wrap),
        .data      (data),
`ifdef CHSEQ_MASK_EN
        .ch_mask   (ch_mask),
`endif
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: phase 0 = idle, 1 = sending, 2 = finishing pulse.
    int                m_phase = 0;
    int                m_q[$];
    bit                m_wrap  = 1'b0;
    logic [NUM_CH-1:0] m_mask  = {NUM_CH{1'b1}};

    // Observations taken from the DUT.
    int obs_log[$];
    int exp_log[$];
    int done_cyc;
    bit done_seen;

    localparam logic [NUM_CH-1:0] ALL_ON = {NUM_CH{1'b1}};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_fill();
        m_q.delete();
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m_mask[i]) m_q.push_back(i);
        end
    endtask

    task automatic check_outputs();
        logic             e_valid;
        logic [WIDTH-1:0] e_data;
        int               e_ch;
        logic             e_last;
        e_valid = (m_phase == 1);
        e_ch    = e_valid ? m_q[0] : 0;
        e_data  = e_valid ? data[e_ch*WIDTH +: WIDTH] : '0;
        e_last  = e_valid && (m_q.size() == 1);
        chk("out_valid", 64'(out_valid), 64'(e_valid));
        chk("out_data",  64'(out_data),  64'(e_data));
        chk("out_ch",    64'(out_ch),    64'(e_ch));
        chk("out_last",  64'(out_last),  64'(e_last));
        chk("busy",      64'(busy),      64'(m_phase != 0));
        chk("done",      64'(done),      64'(m_phase == 2));
        if (out_valid === 1'b1 && out_ready === 1'b1) obs_log.push_back(int'(out_ch));
        if (done === 1'b1) begin
            done_cyc  = cyc;
            done_seen = 1'b1;
        end
    endtask

    task automatic model_adv(input logic st, input logic sp, input logic mw,
                             input logic rdy, input logic [NUM_CH-1:0] mk);
        case (m_phase)
            0: if (st && !sp) begin
                m_wrap = mw;
                m_mask = mk;
                m_fill();
                m_phase = (m_q.size() == 0) ? 2 : 1;
            end
            1: if (sp) begin
                m_phase = 0;
                m_q.delete();
            end else if (rdy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (m_wrap) m_fill();
                    else m_phase = 2;
                end
            end
            default: m_phase = 0;
        endcase
    endtask

    // One clock cycle: drive inputs at the falling edge, check, advance the model.
    task automatic step(input logic st, input logic sp, input logic mw,
                        input logic rdy, input logic [NUM_CH-1:0] mk);
        start = st; stop = sp; mode_wrap = mw; out_ready = rdy;
`ifdef CHSEQ_MASK_EN
        ch_mask = mk;
`endif
        #1;
        check_outputs();
        model_adv(st, sp, mw, rdy, mk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, 64'(obs_log.size()), 64'(exp_log.size()));
        for (int i = 0; i < exp_log.size(); i++) begin
            if (i < obs_log.size()) chk(tag, 64'(obs_log[i]), 64'(exp_log[i]));
        end
    endtask

    initial begin
        int t0;
        logic [NUM_CH-1:0] rmask;
        reset = 1'b0; start = 1'b0; stop = 1'b0; mode_wrap = 1'b0; out_ready = 1'b0;
        data = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
`ifdef CHSEQ_MASK_EN
        ch_mask = '0;
`endif
        #2;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_done",  64'(done),      64'd0);
        chk("rst_data",  64'(out_data),  64'd0);
        @(negedge clk);
        reset = 1'b1;

        // One-shot with ready held high.
        obs_log.delete(); done_seen = 0; t0 = cyc;
        step(1, 0, 0, 1, ALL_ON);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, ALL_ON);
        exp_log = '{3, 2, 1, 0};
        check_log("oneshot_seq");
        chk("oneshot_done_cyc", 64'(done_cyc - t0), 64'd5);

        // One-shot with ready toggling.
        obs_log.delete();
        step(1, 0, 0, 1, ALL_ON);
        for (int i = 0; i < 12; i++) step(0, 0, 0, (i % 2 == 0), ALL_ON);
        check_log("toggle_seq");

        // Wrap mode for 10 beats, then stop.
        obs_log.delete(); done_seen = 0;
        step(1, 0, 1, 1, ALL_ON);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, ALL_ON);
        step(0, 1, 0, 0, ALL_ON);
        step(0, 0, 0, 1, ALL_ON);
        chk("wrap_idle_busy", 64'(busy), 64'd0);
        exp_log = '{3, 2, 1, 0, 3, 2, 1, 0, 3, 2};
        check_log("wrap_seq");
        chk("wrap_no_done", 64'(done_seen), 64'd0);

        // start with stop in IDLE, then start again mid-run.
        obs_log.delete();
        step(1, 1, 0, 1, ALL_ON);
        step(0, 0, 0, 1, ALL_ON);
        step(1, 0, 0, 1, ALL_ON);
        step(0, 0, 0, 1, ALL_ON);
        step(1, 0, 0, 1, ALL_ON);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, ALL_ON);
        exp_log = '{3, 2, 1, 0};
        check_log("restart_ignored");

        // Asynchronous reset mid-run at channel 1.
        step(1, 0, 0, 1, ALL_ON);
        step(0, 0, 0, 1, ALL_ON);
        step(0, 0, 0, 1, ALL_ON);
        out_ready = 1'b0;
        #1;
        chk("pre_rst_ch", 64'(out_ch), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data",  64'(out_data),  64'd0);
        chk("arst_ch",    64'(out_ch),    64'd0);
        chk("arst_last",  64'(out_last),  64'd0);
        chk("arst_busy",  64'(busy),      64'd0);
        chk("arst_done",  64'(done),      64'd0);
        m_phase = 0; m_q.delete(); m_wrap = 0;
        @(negedge clk);
        reset = 1'b1;
        obs_log.delete();
        step(1, 0, 0, 1, ALL_ON);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, ALL_ON);
        exp_log = '{3, 2, 1, 0};
        check_log("after_reset");

`ifdef CHSEQ_MASK_EN
        obs_log.delete();
        step(1, 0, 0, 1, 4'b1010);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 4'b1010);
        exp_log = '{3, 1};
        check_log("mask_seq");
        obs_log.delete(); done_seen = 0; t0 = cyc;
        step(1, 0, 0, 1, 4'b0000);
        step(0, 0, 0, 1, 4'b0000);
        step(0, 0, 0, 1, 4'b0000);
        chk("mask0_done_cyc", 64'(done_cyc - t0), 64'd1);
        chk("mask0_beats", 64'(obs_log.size()), 64'd0);
`endif

        // Random stimulus against the model.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NUM_CH; k++) data[k*WIDTH +: WIDTH] = $urandom;
`ifdef CHSEQ_MASK_EN
            rmask = NUM_CH'($urandom);
`else
            rmask = ALL_ON;
`endif
            step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                 1'($urandom), ($urandom_range(0, 2) != 0), rmask);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
